binary_morph3x3: RTL and testbench
==================================

Name: binary_morph3x3

Overview:
- Streaming 3x3 binary morphology stage (erosion or dilation) directly downstream of the grayscale thresholding stage in the DVP video-processing chain.
- Consumes the 1-bit monochrome pixel stream plus vsync/hsync/de.
- Emits a filtered 1-bit stream with sync signals delay-matched, for the projection and feature stages that follow.
- Two 1-bit line buffers provide the vertical neighbourhood.

Parameters:
- H_MAX, 1024, maximum active pixels per line; sets line-buffer depth.
- MODE, 0, 0 = erosion (AND of 9 taps), 1 = dilation (OR of 9 taps).
- CW, 11, column counter width; must satisfy 2^CW >= H_MAX.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- pre_frame_vsync  in  1  frame sync, active-high; rising edge starts a frame
- pre_frame_hsync  in  1  line sync, passed through only
- pre_frame_de  in  1  active-pixel enable
- monoc  in  1  input pixel (1 = white, 0 = black)
- post_frame_vsync  out  1  vsync delayed 3 clk
- post_frame_hsync  out  1  hsync delayed 3 clk
- post_frame_de  out  1  de delayed 3 clk
- monoc_out  out  1  filtered pixel; 0 whenever post_frame_de = 0

Behaviour:
- Reset (async): all outputs 0, sync delay pipes 0, window registers 0, col_cnt = 0, row_cnt = 0. Line-buffer RAM contents are not reset; border masking covers them.
- Counters:
  - col_cnt increments on each de=1 cycle, saturates at H_MAX, and clears on the de falling edge.
  - row_cnt increments on each de falling edge, saturates at 2, and clears on the vsync rising edge.
  - Both are sampled with the pixel at input time.
- Line buffers:
  - lb1 holds row r-1; lb2 holds row r-2.
  - Addressed by col_cnt, read-first, 1-cycle read latency.
  - On a de=1 cycle with col_cnt < H_MAX: lb1[c] <= monoc and lb2[c] <= old lb1[c].
  - No write when col_cnt >= H_MAX; the address never wraps.
- Pipeline, fixed 3 clk:
  - S1: register monoc, de, and the mask flag; lb reads return.
  - S2: shift the three vertical taps into a 3x3 window (3 columns x 3 rows).
  - S3: AND (MODE 0) or OR (MODE 1) of all 9 taps, masked, gated by de, registered to monoc_out.
- Output geometry: monoc_out at input position (r, c) reflects the window rows r-2..r, cols c-2..c, i.e. the image is shifted by one row and one column.
- Border mask: output forced to 0 when, at input time, row_cnt < 2, col_cnt < 2, or col_cnt >= H_MAX. Applies in both modes.
- Window shift: the window shifts only on de=1 cycles. At the start of each line the window is flushed by the col < 2 mask, so there is no carry-over between lines.
- Sync outputs: post_* equal pre_* delayed exactly 3 clk; hsync is not interpreted.
- vsync rising during an active line: row_cnt clears immediately; col_cnt unaffected.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, the first two lines seen are masked until row_cnt reaches 2, even if no vsync has arrived.
- Simultaneous de falling edge and vsync rising edge in the same cycle: the vsync clear wins and row_cnt = 0.

Decomposition:
- Shared package (vp_pkg): MORPH_ERODE = 0, MORPH_DILATE = 1, VP_SYNC_LAT_MORPH = 3. Downstream stages use the latency constant for alignment.
- One sub-module, vp_linebuf_1b: single-port read-first 1-bit RAM, depth H_MAX, 1-cycle read latency. It is instantiated twice.

Test Plan:
- Setup for all scenarios: H_MAX = 16, frames of 8 pixels x 6 lines with 2-clk line blanking.
- MODE 0, all-ones frame -> monoc_out = 1 exactly at input rows 2..5, cols 2..7 (24 ones per frame), 0 elsewhere.
- MODE 0, all-ones with a single 0 at (3,4) -> ones at rows 2..5, cols 2..7 except rows 3..5 x cols 4..6 (15 ones).
- MODE 1, all-zeros with a single 1 at (3,4) -> exactly 9 ones, at rows 3..5 x cols 4..6.
- Random sync/de patterns -> post_frame_vsync/hsync/de equal inputs delayed 3 clk, bit-exact. monoc_out = 0 on every cycle with post_frame_de = 0.
- Overflow: 20-pixel line with H_MAX = 16 in an all-ones frame, MODE 0 -> cols 16..19 output 0. The next 8-pixel lines give the same result as the first scenario (no RAM corruption).
- Reset mid-frame:
  - assert rst_n = 0 at row 3, col 5 -> all outputs 0 within the same cycle;
  - release with no new vsync -> next two lines output 0;
  - next full frame -> matches the first scenario.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared constants and helpers for the DVP video-processing chain.
// Downstream stages use VP_SYNC_LAT_MORPH to align with the morphology stage.
package vp_pkg;

    localparam int MORPH_ERODE       = 0;
    localparam int MORPH_DILATE      = 1;
    localparam int VP_SYNC_LAT_MORPH = 3;

    typedef struct packed {
        logic vsync;
        logic hsync;
        logic de;
    } vp_sync_t;

    // Erosion keeps a pixel only if all nine taps are set; dilation if any tap is set.
    function automatic logic morph_reduce(input logic [8:0] taps, input logic dilate);
        logic r;
        if (dilate) begin
            r = |taps;
        end else begin
            r = &taps;
        end
        return r;
    endfunction

endpackage

// File: rtl/vp_linebuf_1b.sv
// Single-port read-first 1-bit line buffer with a registered read (1 clk latency).
// Contents are intentionally not reset; the consumer masks rows that are not yet valid.
module vp_linebuf_1b #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          din,
    output logic          dout
);

    logic mem [DEPTH];
    logic dout_q;

    // Read-first access: dout returns the value held before this cycle's write.
    always_ff @(posedge clk) begin
        if (en) begin
            dout_q <= mem[addr];
            if (we) begin
                mem[addr] <= din;
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/binary_morph3x3.sv
// Streaming 3x3 binary erosion/dilation with two cascaded 1-bit line buffers.
// Output and sync signals are delayed by exactly VP_SYNC_LAT_MORPH clocks.
module binary_morph3x3
    import vp_pkg::*;
#(
    parameter int H_MAX = 1024,
    parameter int MODE  = MORPH_ERODE,
    parameter int CW    = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pre_frame_vsync,
    input  logic pre_frame_hsync,
    input  logic pre_frame_de,
    input  logic monoc,
    output logic post_frame_vsync,
    output logic post_frame_hsync,
    output logic post_frame_de,
    output logic monoc_out
);

    localparam int            LB_AW  = (H_MAX > 1) ? $clog2(H_MAX) : 1;
    localparam logic [CW-1:0] H_LIM  = H_MAX[CW-1:0];
    localparam logic          DILATE = (MODE == MORPH_DILATE) ? 1'b1 : 1'b0;

    logic [CW-1:0]    col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic             de_prev_q, de_prev_d;
    logic             vs_prev_q, vs_prev_d;
    vp_sync_t         sync_s1_q, sync_s1_d, sync_s2_q, sync_s2_d, sync_s3_q, sync_s3_d;
    logic             pix_s1_q, pix_s1_d, pix_s2_q, pix_s2_d;
    logic             r1_s2_q, r1_s2_d;
    logic             valid_s1_q, valid_s1_d, valid_s2_q, valid_s2_d;
    logic             lb_en_s1_q, lb_en_s1_d;
    logic [LB_AW-1:0] col_s1_q, col_s1_d;
    logic [5:0]       win_q, win_d;
    logic             out_q, out_d;

    logic             lb_en_s;
    logic             de_fall_s;
    logic             vs_rise_s;
    logic             lb1_dout_s;
    logic             lb2_dout_s;
    logic [2:0]       new_col_s;

    // lb2 runs one stage behind lb1 so it can store lb1's read-first output
    // (the old row r-1) while still using a single port per buffer.
    vp_linebuf_1b #(.DEPTH(H_MAX), .AW(LB_AW)) u_lb1 (
        .clk  (clk),
        .en   (lb_en_s),
        .we   (lb_en_s),
        .addr (col_q[LB_AW-1:0]),
        .din  (monoc),
        .dout (lb1_dout_s)
    );

    vp_linebuf_1b #(.DEPTH(H_MAX), .AW(LB_AW)) u_lb2 (
        .clk  (clk),
        .en   (lb_en_s1_q),
        .we   (lb_en_s1_q),
        .addr (col_s1_q),
        .din  (lb1_dout_s),
        .dout (lb2_dout_s)
    );

    // Input-side counters, edge detection and border mask.
    always_comb begin
        de_fall_s = de_prev_q & ~pre_frame_de;
        vs_rise_s = pre_frame_vsync & ~vs_prev_q;
        lb_en_s   = pre_frame_de & (col_q < H_LIM);
        de_prev_d = pre_frame_de;
        vs_prev_d = pre_frame_vsync;

        if (pre_frame_de) begin
            if (col_q == H_LIM) begin
                col_d = col_q;
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = {CW{1'b0}};
        end

        if (vs_rise_s) begin
            row_d = 2'd0;
        end else if (de_fall_s && (row_q != 2'd2)) begin
            row_d = row_q + 2'd1;
        end else begin
            row_d = row_q;
        end
    end

    // Pipeline: S1 captures the pixel, S2 aligns the r-1 tap with lb2's r-2 read,
    // S3 reduces the incoming column together with the two stored columns.
    always_comb begin
        sync_s1_d  = {pre_frame_vsync, pre_frame_hsync, pre_frame_de};
        sync_s2_d  = sync_s1_q;
        sync_s3_d  = sync_s2_q;
        pix_s1_d   = monoc;
        pix_s2_d   = pix_s1_q;
        r1_s2_d    = lb1_dout_s;
        valid_s1_d = lb_en_s & (row_q == 2'd2) & (col_q >= CW'(2));
        valid_s2_d = valid_s1_q;
        lb_en_s1_d = lb_en_s;
        col_s1_d   = col_q[LB_AW-1:0];

        new_col_s  = {pix_s2_q, r1_s2_q, lb2_dout_s};
        out_d      = sync_s2_q.de & valid_s2_q & morph_reduce({new_col_s, win_q}, DILATE);

        if (sync_s2_q.de) begin
            win_d = {new_col_s, win_q[5:3]};
        end else begin
            win_d = win_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= {CW{1'b0}};
            row_q      <= 2'd0;
            de_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            sync_s1_q  <= 3'b000;
            sync_s2_q  <= 3'b000;
            sync_s3_q  <= 3'b000;
            pix_s1_q   <= 1'b0;
            pix_s2_q   <= 1'b0;
            r1_s2_q    <= 1'b0;
            valid_s1_q <= 1'b0;
            valid_s2_q <= 1'b0;
            lb_en_s1_q <= 1'b0;
            col_s1_q   <= {LB_AW{1'b0}};
            win_q      <= 6'b000000;
            out_q      <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            de_prev_q  <= de_prev_d;
            vs_prev_q  <= vs_prev_d;
            sync_s1_q  <= sync_s1_d;
            sync_s2_q  <= sync_s2_d;
            sync_s3_q  <= sync_s3_d;
            pix_s1_q   <= pix_s1_d;
            pix_s2_q   <= pix_s2_d;
            r1_s2_q    <= r1_s2_d;
            valid_s1_q <= valid_s1_d;
            valid_s2_q <= valid_s2_d;
            lb_en_s1_q <= lb_en_s1_d;
            col_s1_q   <= col_s1_d;
            win_q      <= win_d;
            out_q      <= out_d;
        end
    end

    assign post_frame_vsync = sync_s3_q.vsync;
    assign post_frame_hsync = sync_s3_q.hsync;
    assign post_frame_de    = sync_s3_q.de;
    assign monoc_out        = out_q;

endmodule

// File: tb/tb_binary_morph3x3.sv
// Self-checking bench: an erosion and a dilation instance share one stimulus stream
// and are compared cycle by cycle against an array-based reference model.
module tb_binary_morph3x3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic vs = 1'b0, hs = 1'b0, de = 1'b0, pix = 1'b0;
    logic pv0, ph0, pd0, mo0, pv1, ph1, pd1, mo1;

    always #5 clk = ~clk;

    binary_morph3x3 #(.H_MAX(16), .MODE(0), .CW(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .pre_frame_vsync(vs), .pre_frame_hsync(hs),
        .pre_frame_de(de), .monoc(pix), .post_frame_vsync(pv0), .post_frame_hsync(ph0),
        .post_frame_de(pd0), .monoc_out(mo0));

    binary_morph3x3 #(.H_MAX(16), .MODE(1), .CW(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .pre_frame_vsync(vs), .pre_frame_hsync(hs),
        .pre_frame_de(de), .monoc(pix), .post_frame_vsync(pv1), .post_frame_hsync(ph1),
        .post_frame_de(pd1), .monoc_out(mo1));

    typedef struct packed { logic vs; logic hs; logic de; logic o0; logic o1; } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   ones0 = 0, ones1 = 0;
    exp_t expq[$];

    // Reference model state: line-buffer contents, this line's column taps, counters.
    int   lb1m[16], lb2m[16];
    int   tp[32], t1[32], t2[32];
    int   m_col = 0, m_line = 0;
    logic m_de_prev = 1'b0, m_vs_prev = 1'b0;
    int   img[6][24];

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs == expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_push(input logic v, input logic h, input logic d, input logic p);
        exp_t e;
        int   c, r1, r2, a, o;
        e = {v, h, d, 1'b0, 1'b0};
        if (d) begin
            c  = m_col;
            r1 = 0;
            r2 = 0;
            if (c < 16) begin
                r1 = lb1m[c];
                r2 = lb2m[c];
                lb2m[c] = lb1m[c];
                lb1m[c] = int'(p);
            end
            if (c < 32) begin
                tp[c] = int'(p);
                t1[c] = r1;
                t2[c] = r2;
            end
            if (m_line >= 2 && c >= 2 && c < 16) begin
                a = 1;
                o = 0;
                for (int k = c - 2; k <= c; k++) begin
                    a = a & tp[k] & t1[k] & t2[k];
                    o = o | tp[k] | t1[k] | t2[k];
                end
                e.o0 = a[0];
                e.o1 = o[0];
            end
            m_col = c + 1;
        end else begin
            m_col = 0;
        end
        if (v && !m_vs_prev) m_line = 0;
        else if (m_de_prev && !d) m_line++;
        m_de_prev = d;
        m_vs_prev = v;
        expq.push_back(e);
    endtask

    task automatic step(input logic v, input logic h, input logic d, input logic p);
        exp_t e;
        @(negedge clk);
        if (expq.size() >= 3) begin
            e = expq.pop_front();
            chk("sync_erode", {pv0, ph0, pd0}, {e.vs, e.hs, e.de});
            chk("sync_dilate", {pv1, ph1, pd1}, {e.vs, e.hs, e.de});
            chk("out_erode", {2'b00, mo0}, {2'b00, e.o0});
            chk("out_dilate", {2'b00, mo1}, {2'b00, e.o1});
            ones0 += int'(mo0);
            ones1 += int'(mo1);
        end
        vs = v; hs = h; de = d; pix = p;
        model_push(v, h, d, p);
    endtask

    task automatic after_reset();
        expq.delete();
        repeat (3) expq.push_back('0);
        m_line = 0; m_col = 0; m_de_prev = 1'b0; m_vs_prev = 1'b0;
    endtask

    task automatic fill(input int val);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 24; c++) img[r][c] = val;
    endtask

    task automatic line(input int r, input int len);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < len; c++) step(1'b0, 1'b0, 1'b1, 1'(img[r][c]));
    endtask

    task automatic run_frame(input int len2);
        ones0 = 0;
        ones1 = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) line(r, (r == 2) ? len2 : 8);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic rv, rd;
        int   run;

        for (int i = 0; i < 16; i++) begin lb1m[i] = 0; lb2m[i] = 0; end

        #2 rst_n = 1'b0;
        #1;
        chk("reset_erode", {pv0, ph0, pd0}, 3'b000);
        chk("reset_dilate", {pv1, ph1, pd1}, 3'b000);
        chk("reset_out", {1'b0, mo0, mo1}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        after_reset();

        // Two full-width zero lines give every line-buffer word a known value.
        fill(0);
        line(0, 16);
        line(1, 16);

        fill(1);
        run_frame(8);
        chk_int("ones_all_erode", ones0, 24);
        chk_int("ones_all_dilate", ones1, 24);

        fill(1);
        img[3][4] = 0;
        run_frame(8);
        chk_int("ones_hole_erode", ones0, 15);
        chk_int("ones_hole_dilate", ones1, 24);

        fill(0);
        img[3][4] = 1;
        run_frame(8);
        chk_int("ones_dot_dilate", ones1, 9);
        chk_int("ones_dot_erode", ones0, 0);

        fill(1);
        run_frame(20);
        chk_int("ones_overflow_erode", ones0, 24);
        run_frame(8);
        chk_int("ones_after_overflow", ones0, 24);

        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 24; c++) img[r][c] = ($urandom_range(0, 9) < 8) ? 1 : 0;
            run_frame(8);
        end

        fill(0);
        line(0, 16);
        line(1, 16);
        rd = 1'b0;
        run = 0;
        for (int i = 0; i < 800; i++) begin
            rv = ($urandom_range(0, 119) == 0);
            if (rd) begin
                if (run >= 24 || $urandom_range(0, 9) == 0) rd = 1'b0;
            end else begin
                rd = ($urandom_range(0, 2) == 0);
            end
            run = rd ? run + 1 : 0;
            step(rv, 1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)));
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of row 3, column 5 of an all-ones frame.
        fill(1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) line(r, 8);
        line(3, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_erode", {pv0, ph0, pd0}, 3'b000);
        chk("midrst_dilate", {pv1, ph1, pd1}, 3'b000);
        chk("midrst_out", {1'b0, mo0, mo1}, 3'b000);
        vs = 1'b0; hs = 1'b0; de = 1'b0; pix = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        after_reset();

        ones0 = 0;
        ones1 = 0;
        line(0, 8);
        line(1, 8);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_int("post_reset_lines_erode", ones0, 0);
        chk_int("post_reset_lines_dilate", ones1, 0);

        run_frame(8);
        chk_int("post_reset_frame", ones0, 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
